// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with two prioritised write ports,
// optional write-to-read bypass and a per-register pending-write scoreboard.
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int NRP    = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NRP*AW-1:0]          i_rd_addr,
    output logic signed [NRP*XLEN-1:0] o_rd_data,
    output logic [NRP-1:0]             o_rd_busy,
    input  logic                       i_we0,
    input  logic [AW-1:0]              i_wa0,
    input  logic [XLEN-1:0]            i_wd0,
    input  logic                       i_we1,
    input  logic [AW-1:0]              i_wa1,
    input  logic [XLEN-1:0]            i_wd1,
    input  logic                       i_sb_set,
    input  logic [AW-1:0]              i_sb_addr,
    output logic [AW:0]                o_pending_cnt
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_pending_cnt;

    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     w_cnt_nxt;
    logic            w_we0_ok;
    logic            w_we1_ok;
    logic            w_sb_ok;
    logic [AW-1:0]   w_addr [NRP];
    logic [NRP-1:0]  w_addr_ok;

    // Register 0 and addresses beyond NREG are never written, set or read back.
    function automatic logic validAddr(input logic [AW-1:0] a);
        return (32'(a) < NREG) && (a != '0);
    endfunction

    assign w_we0_ok = i_we0 && validAddr(i_wa0);
    assign w_we1_ok = i_we1 && validAddr(i_wa1);
    assign w_sb_ok  = i_sb_set && validAddr(i_sb_addr);

    for (genvar g = 0; g < NRP; g++) begin : g_addr
        assign w_addr[g]    = i_rd_addr[g*AW +: AW];
        assign w_addr_ok[g] = validAddr(w_addr[g]);
    end

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_we0_ok) begin
                r_regs[i_wa0] <= i_wd0;
            end
            if (w_we1_ok) begin
                r_regs[i_wa1] <= i_wd1;
            end
        end
    end

    // Set is applied after clear: a newly issued producer keeps the register busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_we1_ok) begin
            w_busy_nxt[i_wa1] = 1'b0;
        end
        if (w_sb_ok) begin
            w_busy_nxt[i_sb_addr] = 1'b1;
        end
        w_cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy        <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_busy        <= w_busy_nxt;
            r_pending_cnt <= w_cnt_nxt;
        end
    end

    assign o_pending_cnt = r_pending_cnt;

    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int p = 0; p < NRP; p++) begin
            if (w_addr_ok[p]) begin
                o_rd_data[p*XLEN +: XLEN] = r_regs[w_addr[p]];
                o_rd_busy[p]              = r_busy[w_addr[p]];
                if (BYPASS != 0) begin
                    if (w_we0_ok && (i_wa0 == w_addr[p])) begin
                        o_rd_data[p*XLEN +: XLEN] = i_wd0;
                    end
                    if (w_we1_ok && (i_wa1 == w_addr[p])) begin
                        o_rd_data[p*XLEN +: XLEN] = i_wd1;
                        o_rd_busy[p]              = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomised and directed bench for regfile_mp_sb, driving a bypassing and a
// non-bypassing instance from the same stimulus against one reference model.
module tb_regfile_mp_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRP  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     rdA [NRP];
    logic [NRP*AW-1:0] rdAddr;
    logic              we0, we1, sbSet;
    logic [AW-1:0]     wa0, wa1, sbAddr;
    logic [XLEN-1:0]   wd0, wd1;

    logic signed [NRP*XLEN-1:0] dataByp, dataNoByp;
    logic [NRP-1:0]             busyByp, busyNoByp;
    logic [AW:0]                cntByp, cntNoByp;

    logic [XLEN-1:0] mMem [NREG];
    bit              mBusy [NREG];
    int              mCnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rdAddr = {rdA[1], rdA[0]};

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP), .BYPASS(1)) dutByp (
        .clk(clk), .rst_n(rst_n), .i_rd_addr(rdAddr), .o_rd_data(dataByp),
        .o_rd_busy(busyByp), .i_we0(we0), .i_wa0(wa0), .i_wd0(wd0),
        .i_we1(we1), .i_wa1(wa1), .i_wd1(wd1), .i_sb_set(sbSet),
        .i_sb_addr(sbAddr), .o_pending_cnt(cntByp)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP), .BYPASS(0)) dutNoByp (
        .clk(clk), .rst_n(rst_n), .i_rd_addr(rdAddr), .o_rd_data(dataNoByp),
        .o_rd_busy(busyNoByp), .i_we0(we0), .i_wa0(wa0), .i_wd0(wd0),
        .i_we1(we1), .i_wa1(wa1), .i_wd1(wd1), .i_sb_set(sbSet),
        .i_sb_addr(sbAddr), .o_pending_cnt(cntNoByp)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [XLEN-1:0] expRead(input logic [AW-1:0] a, input bit byp);
        if (a == 0 || int'(a) >= NREG) return '0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return mMem[a];
    endfunction

    function automatic bit expBusy(input logic [AW-1:0] a, input bit byp);
        if (a == 0 || int'(a) >= NREG) return 1'b0;
        return mBusy[a] && !(byp && we1 && wa1 == a);
    endfunction

    // Architectural effect of one clock edge, in spec terms.
    task automatic modelEdge();
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mMem[i]  = '0;
                mBusy[i] = 1'b0;
            end
        end else begin
            if (we0 && wa0 != 0) mMem[wa0] = wd0;
            if (we1 && wa1 != 0) mMem[wa1] = wd1;
            if (we1) mBusy[wa1] = 1'b0;
            if (sbSet && sbAddr != 0) mBusy[sbAddr] = 1'b1;
        end
        mCnt = 0;
        for (int i = 0; i < NREG; i++) mCnt += int'(mBusy[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic checkAll(input string tag);
        #1;
        for (int p = 0; p < NRP; p++) begin
            checkOutput($sformatf("%s byp data p%0d a%0d", tag, p, rdA[p]),
                        64'(dataByp[p*XLEN +: XLEN]), 64'(expRead(rdA[p], 1'b1)));
            checkOutput($sformatf("%s nobyp data p%0d a%0d", tag, p, rdA[p]),
                        64'(dataNoByp[p*XLEN +: XLEN]), 64'(expRead(rdA[p], 1'b0)));
            checkOutput($sformatf("%s byp busy p%0d a%0d", tag, p, rdA[p]),
                        64'(busyByp[p]), 64'(expBusy(rdA[p], 1'b1)));
            checkOutput($sformatf("%s nobyp busy p%0d a%0d", tag, p, rdA[p]),
                        64'(busyNoByp[p]), 64'(expBusy(rdA[p], 1'b0)));
        end
        checkOutput({tag, " byp cnt"}, 64'(cntByp), 64'(mCnt));
        checkOutput({tag, " nobyp cnt"}, 64'(cntNoByp), 64'(mCnt));
    endtask

    task automatic applyStimulus(input bit e0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                                 input bit e1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                                 input bit s, input logic [AW-1:0] sa);
        we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1;
        sbSet = s; sbAddr = sa;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        rdA[0] = '0;
        rdA[1] = '0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < NREG; i++) begin
            rdA[0] = AW'(i);
            rdA[1] = AW'(NREG - 1 - i);
            checkAll("reset");
        end

        rdA[0] = 5; rdA[1] = 0;
        applyStimulus(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0);
        checkAll("wr x5 same");
        tick();
        idle();
        checkAll("wr x5 next");

        rdA[0] = 0; rdA[1] = 5;
        applyStimulus(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0);
        checkAll("wr x0 same");
        tick();
        idle();
        checkAll("wr x0 next");

        rdA[0] = 7; rdA[1] = 7;
        applyStimulus(1, 7, 32'hAAAA_AAAA, 1, 7, 32'h5555_5555, 0, 0);
        checkAll("dual x7 same");
        tick();
        idle();
        checkAll("dual x7 next");

        rdA[0] = 3; rdA[1] = 9;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
        tick();
        idle();
        checkAll("sb x3 set");
        applyStimulus(0, 0, 0, 1, 3, 32'h42, 0, 0);
        checkAll("sb x3 clr same");
        tick();
        idle();
        checkAll("sb x3 clr next");

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        applyStimulus(0, 0, 0, 1, 9, 32'h99, 1, 9);
        checkAll("sb x9 collide same");
        tick();
        idle();
        checkAll("sb x9 collide next");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkAll("mid reset");
        applyStimulus(0, 0, 0, 1, 9, 32'h77, 0, 0);
        tick();
        idle();
        checkAll("late wr after reset");

        // Narrow address ranges force port, bypass and scoreboard collisions.
        for (int n = 0; n < 600; n++) begin
            bit wide;
            wide = ($urandom_range(0, 3) == 0);
            rst_n  = ($urandom_range(0, 59) != 0);
            we0    = 1'($urandom);
            we1    = 1'($urandom);
            sbSet  = ($urandom_range(0, 2) == 0);
            wa0    = wide ? AW'($urandom) : AW'($urandom_range(0, 6));
            wa1    = wide ? AW'($urandom) : AW'($urandom_range(0, 6));
            sbAddr = wide ? AW'($urandom) : AW'($urandom_range(0, 6));
            wd0    = $urandom;
            wd1    = $urandom;
            rdA[0] = wide ? AW'($urandom) : AW'($urandom_range(0, 6));
            rdA[1] = wide ? AW'($urandom) : AW'($urandom_range(0, 6));
            checkAll("rand");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-write-port integer register file for the RV32 core pipeline.
- Adds a configurable number of read ports, two write ports with fixed priority, and optional same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard so decode can stall on long-latency results (loads, multiply/divide).
- Sits between the decode stage (reads, scoreboard set) and the writeback/late-completion paths.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- AW, 5, address width; must satisfy 2**AW >= NREG.
- NRP, 2, number of read ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see only stored values.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- rd_addr  in  NRP*AW  read addresses; port p uses bits [p*AW +: AW].
- rd_data  out  NRP*XLEN  read data, combinational, signed.
- rd_busy  out  NRP  per-port scoreboard pending flag for the addressed register.
- we0  in  1  write enable, port 0 (in-order ALU writeback).
- wa0  in  AW  write address, port 0.
- wd0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (late completion: load/MUL/DIV).
- wa1  in  AW  write address, port 1.
- wd1  in  XLEN  write data, port 1.
- sb_set  in  1  marks register sb_addr pending (long-latency op issued).
- sb_addr  in  AW  register to mark pending.
- pending_cnt  out  AW+1  number of registers currently marked pending.

Behaviour:
- Reset: synchronous on clk rising edge while rst_n = 0.
  - All NREG registers cleared to 0; all busy bits cleared; pending_cnt = 0.
  - Writes and sb_set are ignored during reset.
  - After the reset edge, every rd_data = 0 and every rd_busy = 0.
- Register 0:
  - Reads always return 0.
  - Writes to address 0 are discarded on both ports; never bypassed.
  - sb_set to address 0 is ignored; register 0 is never busy.
- Addresses >= NREG (when NREG < 2**AW):
  - Writes discarded; sb_set ignored.
  - Reads return 0 with busy 0.
- Write commit: registers update on the clk rising edge when weN = 1 (one-cycle write latency).
  - Both ports to the same nonzero address in one cycle: port 1 wins; port 0 data is dropped.
- Read path, combinational, per port p with address A:
  - BYPASS = 1 priority: A = 0 -> 0; else we1 & wa1 = A -> wd1; else we0 & wa0 = A -> wd0; else stored value.
  - BYPASS = 0: stored value only. A read in the same cycle as a write to that address returns the old value; the new value is visible the next cycle.
- Scoreboard, one busy bit per register:
  - Set: sb_set = 1 sets busy[sb_addr] at the clock edge.
  - Clear: we1 = 1 clears busy[wa1] at the clock edge. Port 0 writes never clear busy.
  - Simultaneous sb_set and we1 to the same address: set wins; busy stays 1 because a new producer was issued. The data write still commits.
  - sb_set to an already-busy register: no change (no nesting or counting).
  - we1 to a non-busy register: data written, busy stays 0.
- rd_busy[p]:
  - Computed as busy[A] & ~(BYPASS & we1 & wa1 = A & A != 0).
  - A completing late write is therefore seen as not busy in the same cycle only when bypass is enabled.
- pending_cnt:
  - Registered population count of the busy bits.
  - Updated at the same edge as the busy bits: +1 for an effective set of a non-busy register, -1 for an effective clear, net 0 when both occur on the same register.
  - Range 0..NREG-1.
- Reset mid-operation: all pending state is lost. In-flight late writes arriving after reset are written as normal but clear nothing.

Test Plan:
- Reset, then read all 32 addresses on both ports -> rd_data = 0, rd_busy = 0, pending_cnt = 0.
- Cycle 1: we0 = 1, wa0 = 5, wd0 = 0x1234_5678, with rd_addr[0] = 5 -> BYPASS = 1 gives 0x1234_5678 in the same cycle; BYPASS = 0 gives 0 in the same cycle and 0x1234_5678 the next cycle.
- Write to x0 with wd0 = 0xFFFF_FFFF, then read x0 -> 0; sb_set with sb_addr = 0 -> pending_cnt stays 0.
- Same cycle: we0 = 1, wa0 = 7, wd0 = 0xAAAA_AAAA and we1 = 1, wa1 = 7, wd1 = 0x5555_5555 -> bypass read of x7 = 0x5555_5555; stored value the next cycle = 0x5555_5555.
- Scoreboard sequence:
  - sb_set x3 -> next cycle rd_busy(x3) = 1, pending_cnt = 1.
  - we1 to x3 with 0x42 -> BYPASS = 1 gives rd_busy(x3) = 0 and rd_data = 0x42 in that cycle; next cycle pending_cnt = 0.
- Same cycle: sb_set x9 and we1 to x9 with 0x99 while x9 is busy -> x9 stays busy, stored value 0x99, pending_cnt unchanged; then assert reset -> pending_cnt = 0, all rd_busy = 0.
